// File: rtl/object_package.sv
// Shared declarations for the Meow-Pong movable-object datapath.
//
// Purpose:
//   Holds the match_state_t encoding. It also holds the default match tuning
//   (win score, serve and point hold lengths, score width). The HUD decodes the
//   same values, so they live here instead of being repeated in each consumer.
//
// Contents:
//   match_state_t          IDLE, SERVE, PLAY, POINT, GAMEOVER (3-bit encoding)
//   WIN_SCORE_DEF          points that end a match
//   SERVE_FRAMES_DEF       frame ticks from SERVE entry to ball launch
//   POINT_FRAMES_DEF       frame ticks frozen after a point
//   SCORE_W_DEF            score counter width
//   max_int()              elaboration-time helper for sizing counters
package object_package;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } match_state_t;

  localparam int WIN_SCORE_DEF    = 5;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int POINT_FRAMES_DEF = 30;
  localparam int SCORE_W_DEF      = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame-tick down-counter used for the serve countdown and the
// post-point hold.
//
// Ports:
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset (count clears to 0)
//   load     in   1  load value into the counter; has priority over tick
//   value    in   W  value loaded on load
//   tick     in   1  frame tick; decrements a non-zero count
//   freeze   in   1  holds the count while high
//   expired  out  1  tick & (count == 0): the owning state should exit now
//
// A load of 0 therefore expires on the very first tick after entry.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  input  logic         freeze,
  output logic         expired
);

  logic [W-1:0] count;

  // The counter stops at zero rather than wrapping. The owner sees expiry on
  // the next tick and reloads on its state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && !freeze && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = tick & (count == '0);

endmodule

// File: rtl/match_sequencer.sv
// Round/match sequencer for Meow-Pong.
//
// Purpose:
//   Walks IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAMEOVER) and keeps both
//   scores. It gates the per-frame physics/ai update strobe. It also tells the
//   ball logic when and which way to serve.
//
// Configuration:
//   MATCH_PAUSE_EN  when defined, adds the pause input. A pause rising edge in
//                   SERVE or PLAY toggles a paused flag. While paused, en is 0,
//                   the timer is frozen and misses are ignored. When undefined,
//                   the pause port does not exist and nothing is ever paused.
//
// Ports:
//   clk         in   1        system clock
//   rst_n       in   1        asynchronous active-low reset
//   frame_tick  in   1        one-cycle pulse per video frame
//   start       in   1        synchronised start level (rising edge acts)
//   miss_left   in   1        ball passed left paddle (pulse)
//   miss_right  in   1        ball passed right paddle (pulse)
//   rnum        in   8        LFSR value; bit 0 picks random serve directions
//   pause       in   1        synchronised pause level (MATCH_PAUSE_EN only)
//   en          out  1        physics/ai update strobe
//   serve_req   out  1        pulse: relaunch ball from centre
//   serve_dir   out  1        0 = toward left, 1 = toward right
//   score_l     out  SCORE_W  left (ai) score
//   score_r     out  SCORE_W  right (player) score
//   gameover    out  1        high while in GAMEOVER
//   state       out  3        match_state_t encoding for HUD/debug
module match_sequencer
  import object_package::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic [7:0]         rnum,
`ifdef MATCH_PAUSE_EN
  input  logic               pause,
`endif
  output logic               en,
  output logic               serve_req,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               gameover,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_SERVE    = SERVE;
  localparam logic [2:0] S_PLAY     = PLAY;
  localparam logic [2:0] S_POINT    = POINT;
  localparam logic [2:0] S_GAMEOVER = GAMEOVER;

  localparam int TIMER_MAX = max_int(SERVE_FRAMES, POINT_FRAMES);
  localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic [2:0]         next_state;
  logic               start_q;
  logic               start_rise;
  logic               start_go;
  logic               paused;
  logic               play_live;
  logic               miss_any;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_tick;
  logic               timer_expired;
  logic               rnum_unused;

  // Only bit 0 of the shared LFSR is used for serve direction.
  assign rnum_unused = ^rnum[7:1];

  assign start_rise = start & ~start_q;
  assign start_go   = start_rise & ((state == S_IDLE) | (state == S_GAMEOVER));
  assign play_live  = (state == S_PLAY) & ~paused;
  assign miss_any   = play_live & (miss_left | miss_right);

  // Paused frames never reach the timer. So expiry, and any serve it would
  // trigger, cannot happen while paused.
  assign timer_tick = frame_tick & ~paused;

  assign en       = frame_tick & play_live;
  assign gameover = (state == S_GAMEOVER);

`ifdef MATCH_PAUSE_EN
  logic pause_q;

  // Pause toggles on a rising edge only while the ball is in motion or about
  // to be served. Dropping out of SERVE/PLAY always unpauses. This way a
  // match never resumes frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pause;
      if ((next_state != S_SERVE) && (next_state != S_PLAY)) begin
        paused <= 1'b0;
      end else if (pause && !pause_q &&
                   ((state == S_SERVE) || (state == S_PLAY))) begin
        paused <= ~paused;
      end
    end
  end
`else
  assign paused = 1'b0;
`endif

  frame_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .value  (timer_value),
    .tick   (timer_tick),
    .freeze (paused),
    .expired(timer_expired)
  );

  // Next-state logic. Every transition reloads the timer for the state being
  // entered. PLAY and GAMEOVER load 0 because they never time out.
  // serve_req is the SERVE->PLAY transition cycle itself, so the ball launches
  // on the same frame tick that ends the countdown.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    serve_req   = 1'b0;
    case (state)
      S_IDLE, S_GAMEOVER: begin
        if (start_go) begin
          next_state  = S_SERVE;
          timer_load  = 1'b1;
          timer_value = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        if (timer_expired) begin
          serve_req   = 1'b1;
          next_state  = S_PLAY;
          timer_load  = 1'b1;
        end
      end
      S_PLAY: begin
        if (miss_any) begin
          next_state  = S_POINT;
          timer_load  = 1'b1;
          timer_value = POINT_LOAD;
        end
      end
      S_POINT: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          if ((score_l == WIN_VAL) || (score_r == WIN_VAL)) begin
            next_state = S_GAMEOVER;
          end else begin
            next_state  = S_SERVE;
            timer_value = SERVE_LOAD;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
        timer_load = 1'b1;
      end
    endcase
  end

  // State, scores and serve direction.
  // The side that missed receives the next serve. A double miss is a replay
  // with a random direction and no score change. Scores stop at WIN_SCORE, so
  // a narrow counter can never wrap past the winning value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
      serve_dir <= 1'b0;
    end else begin
      start_q <= start;
      state   <= next_state;
      if (start_go) begin
        score_l   <= '0;
        score_r   <= '0;
        serve_dir <= rnum[0];
      end else if (miss_any) begin
        if (miss_left && !miss_right) begin
          if (score_r < WIN_VAL) begin
            score_r <= score_r + SCORE_W'(1);
          end
          serve_dir <= 1'b0;
        end else if (miss_right && !miss_left) begin
          if (score_l < WIN_VAL) begin
            score_l <= score_l + SCORE_W'(1);
          end
          serve_dir <= 1'b1;
        end else begin
          serve_dir <= rnum[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer.
//
// The DUT is built with short timings (SERVE_FRAMES=3, POINT_FRAMES=2) and
// WIN_SCORE=2, so a complete match fits in a few hundred cycles. A queue holds
// the serve each scenario expects: direction plus both scores. A monitor pops
// and compares an entry whenever serve_req pulses.
// The pause scenario only runs when MATCH_PAUSE_EN is defined.
module tb_match_sequencer;

  localparam int SF = 3;
  localparam int PF = 2;
  localparam int WS = 2;
  localparam int SW = 4;

  typedef struct packed {
    logic          dir;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } serve_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic [7:0]    rnum = 8'h00;
`ifdef MATCH_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic          en;
  logic          serve_req;
  logic          serve_dir;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          gameover;
  logic [2:0]    state;

  int            vectors = 0;
  int            miscompares = 0;
  serve_exp_t    exp_q[$];

  logic          s_en;
  logic          s_srv;
  logic [2:0]    s_state;

  match_sequencer #(
    .WIN_SCORE   (WS),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF),
    .SCORE_W     (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .rnum      (rnum),
`ifdef MATCH_PAUSE_EN
    .pause     (pause),
`endif
    .en        (en),
    .serve_req (serve_req),
    .serve_dir (serve_dir),
    .score_l   (score_l),
    .score_r   (score_r),
    .gameover  (gameover),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every serve_req must match the oldest expected serve.
  always @(negedge clk) begin
    if (rst_n && serve_req) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL serve_unexpected got serve_req=1 dir=%0d l=%0d r=%0d want no serve",
                 serve_dir, score_l, score_r);
      end else begin
        serve_exp_t e;
        e = exp_q.pop_front();
        if ({serve_dir, score_l, score_r} !== {e.dir, e.l, e.r}) begin
          miscompares++;
          $display("[TB] FAIL serve_event got dir=%0d l=%0d r=%0d want dir=%0d l=%0d r=%0d",
                   serve_dir, score_l, score_r, e.dir, e.l, e.r);
        end
      end
    end
  end

  // Applies one cycle of frame_tick/miss stimulus after the rising edge and
  // samples the combinational outputs at the following falling edge.
  task automatic cycle_with(input logic ft, input logic ml, input logic mr);
    @(posedge clk);
    #1;
    frame_tick = ft;
    miss_left  = ml;
    miss_right = mr;
    @(negedge clk);
    s_en    = en;
    s_srv   = serve_req;
    s_state = state;
  endtask

  // Frame ticks through a serve countdown (bounded). n is the tick that
  // carried serve_req, or 0 if none arrived.
  task automatic run_serve(output int n, output int en_hits);
    n = 0;
    en_hits = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle_with(1'b1, 1'b0, 1'b0);
      if (s_en) en_hits++;
      if (s_srv) begin
        n = i;
        break;
      end
    end
    cycle_with(1'b0, 1'b0, 1'b0);
  endtask

  // Applies the full POINT hold, POINT_FRAMES+1 frame ticks.
  task automatic point_hold(output int en_hits);
    en_hits = 0;
    for (int i = 0; i < PF + 1; i++) begin
      cycle_with(1'b1, 1'b0, 1'b0);
      if (s_en) en_hits++;
    end
    cycle_with(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({state, score_l, score_r, serve_dir, gameover, serve_req} !== {3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got st=%0d l=%0d r=%0d dir=%0d go=%0d srv=%0d want all 0",
               state, score_l, score_r, serve_dir, gameover, serve_req);
    end
    cycle_with(1'b1, 1'b0, 1'b0);
    vectors++;
    if (s_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_en got %0d want 0", s_en);
    end
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if (s_state !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_hold got state=%0d want 0", s_state);
    end
  endtask

  task automatic test_serve();
    int n, hits;
    rnum  = 8'h01;
    start = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    vectors++;
    if ({s_state, serve_dir} !== {3'd1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL serve_entry got state=%0d dir=%0d want state=1 dir=1", s_state, serve_dir);
    end
    exp_q.push_back('{dir: 1'b1, l: 4'd0, r: 4'd0});
    run_serve(n, hits);
    vectors++;
    if (n !== SF + 1) begin
      miscompares++;
      $display("[TB] FAIL serve_tick got tick %0d want %0d", n, SF + 1);
    end
    vectors++;
    if (hits !== 0 || s_state !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL serve_to_play got en_hits=%0d state=%0d want 0 and 2", hits, s_state);
    end
    start = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    cycle_with(1'b1, 1'b0, 1'b0);
    vectors++;
    if ({s_state, s_en} !== {3'd2, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL play_first_en got state=%0d en=%0d want state=2 en=1", s_state, s_en);
    end
  endtask

  task automatic test_miss_right();
    int n, hits;
    rnum = 8'h00;
    cycle_with(1'b1, 1'b0, 1'b1);
    vectors++;
    if (s_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL miss_tick_en got %0d want 1", s_en);
    end
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({s_state, score_l, score_r, serve_dir} !== {3'd3, 4'd1, 4'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL miss_right_point got st=%0d l=%0d r=%0d dir=%0d want 3 1 0 1",
               s_state, score_l, score_r, serve_dir);
    end
    exp_q.push_back('{dir: 1'b1, l: 4'd1, r: 4'd0});
    point_hold(hits);
    vectors++;
    if (hits !== 0 || s_state !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL point_hold got en_hits=%0d state=%0d want 0 and 1", hits, s_state);
    end
    run_serve(n, hits);
    vectors++;
    if (n !== SF + 1) begin
      miscompares++;
      $display("[TB] FAIL reserve_tick got tick %0d want %0d", n, SF + 1);
    end
  endtask

  task automatic test_double_miss();
    int n, hits;
    rnum = 8'h00;
    cycle_with(1'b0, 1'b1, 1'b1);
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({s_state, score_l, score_r, serve_dir} !== {3'd3, 4'd1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL double_miss got st=%0d l=%0d r=%0d dir=%0d want 3 1 0 0",
               s_state, score_l, score_r, serve_dir);
    end
    exp_q.push_back('{dir: 1'b0, l: 4'd1, r: 4'd0});
    point_hold(hits);
    run_serve(n, hits);
    vectors++;
    if (s_state !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL replay_play got state=%0d want 2", s_state);
    end
  endtask

  task automatic test_gameover();
    int n, hits;
    cycle_with(1'b0, 1'b1, 1'b0);
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({score_r, serve_dir} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL miss_left_1 got r=%0d dir=%0d want r=1 dir=0", score_r, serve_dir);
    end
    exp_q.push_back('{dir: 1'b0, l: 4'd1, r: 4'd1});
    point_hold(hits);
    run_serve(n, hits);
    cycle_with(1'b0, 1'b1, 1'b0);
    cycle_with(1'b0, 1'b0, 1'b0);
    point_hold(hits);
    vectors++;
    if ({s_state, gameover, score_r} !== {3'd4, 1'b1, 4'd2}) begin
      miscompares++;
      $display("[TB] FAIL gameover_entry got st=%0d go=%0d r=%0d want 4 1 2", s_state, gameover, score_r);
    end
    cycle_with(1'b1, 1'b1, 1'b0);
    hits = int'(s_en);
    cycle_with(1'b1, 1'b0, 1'b1);
    hits += int'(s_en);
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({s_state, score_l, score_r} !== {3'd4, 4'd1, 4'd2} || hits !== 0) begin
      miscompares++;
      $display("[TB] FAIL gameover_misses got st=%0d l=%0d r=%0d en_hits=%0d want 4 1 2 0",
               s_state, score_l, score_r, hits);
    end
    rnum  = 8'h01;
    start = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    vectors++;
    if ({s_state, score_l, score_r, serve_dir, gameover} !== {3'd1, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL restart got st=%0d l=%0d r=%0d dir=%0d go=%0d want 1 0 0 1 0",
               s_state, score_l, score_r, serve_dir, gameover);
    end
    exp_q.push_back('{dir: 1'b1, l: 4'd0, r: 4'd0});
    run_serve(n, hits);
    vectors++;
    if (n !== SF + 1) begin
      miscompares++;
      $display("[TB] FAIL restart_serve got tick %0d want %0d", n, SF + 1);
    end
  endtask

  task automatic test_reset_mid_play();
    int n, hits;
    cycle_with(1'b0, 1'b0, 1'b1);
    cycle_with(1'b0, 1'b0, 1'b0);
    exp_q.push_back('{dir: 1'b1, l: 4'd1, r: 4'd0});
    point_hold(hits);
    run_serve(n, hits);
    cycle_with(1'b1, 1'b0, 1'b0);
    vectors++;
    if (s_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_en got %0d want 1", s_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, score_l, score_r, serve_dir, gameover, serve_req, en} !== {3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset got st=%0d l=%0d r=%0d dir=%0d go=%0d srv=%0d en=%0d want all 0",
               state, score_l, score_r, serve_dir, gameover, serve_req, en);
    end
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      cycle_with(1'b1, 1'b0, 1'b0);
      hits += int'(s_srv) + int'(s_en);
    end
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if (hits !== 0 || s_state !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_release got srv+en hits=%0d state=%0d want 0 and 0", hits, s_state);
    end
  endtask

`ifdef MATCH_PAUSE_EN
  task automatic test_pause();
    int n, hits;
    rnum  = 8'h00;
    start = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    exp_q.push_back('{dir: 1'b0, l: 4'd0, r: 4'd0});
    run_serve(n, hits);
    pause = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      cycle_with(1'b1, 1'b0, 1'b0);
      hits += int'(s_en);
    end
    cycle_with(1'b1, 1'b0, 1'b1);
    hits += int'(s_en);
    cycle_with(1'b0, 1'b0, 1'b0);
    vectors++;
    if (hits !== 0 || {s_state, score_l, score_r} !== {3'd2, 4'd0, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL paused got en_hits=%0d st=%0d l=%0d r=%0d want 0 2 0 0",
               hits, s_state, score_l, score_r);
    end
    pause = 1'b0;
    cycle_with(1'b0, 1'b0, 1'b0);
    pause = 1'b1;
    cycle_with(1'b0, 1'b0, 1'b0);
    cycle_with(1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    vectors++;
    if ({s_en, s_state, score_l, score_r} !== {1'b1, 3'd2, 4'd0, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL resume got en=%0d st=%0d l=%0d r=%0d want 1 2 0 0",
               s_en, s_state, score_l, score_r);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish within 200000 time units want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_serve();
    test_miss_right();
    test_double_miss();
    test_gameover();
    test_reset_mid_play();
`ifdef MATCH_PAUSE_EN
    test_pause();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL serve_queue_drain got %0d pending serves want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
